// File: rtl/ws2812_bit_tx_if.sv
// Word-level handshake between the pixel-sequencing controller (master)
// and the WS2812 bit serializer (slave).
interface ws2812_bit_tx_if;
  logic        tx_en;
  logic [23:0] rgb;
  logic        tx_done;
  logic        busy;

  modport master (output tx_en, rgb, input tx_done, busy);
  modport slave  (input tx_en, rgb, output tx_done, busy);
endinterface

// File: rtl/ws2812_bit_tx.sv
// WS2812 single-wire NRZ serializer: a free-running 24-slot timebase carries one
// colour word per period; idle periods hold the line low to form the latch gap.
module ws2812_bit_tx #(
  parameter int T0H       = 20,
  parameter int T1H       = 40,
  parameter int T_BIT     = 63,
  parameter int GRB_ORDER = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  ws2812_bit_tx_if.slave     bus,
  output logic               o_dout
);

  localparam logic [7:0] C_T0H  = 8'(T0H);
  localparam logic [7:0] C_T1H  = 8'(T1H);
  localparam logic [7:0] C_LAST = 8'(T_BIT - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cyc;
  logic [4:0]  r_bit_idx;
  logic [23:0] r_shreg;
  logic        r_tx_done;
  logic        r_dout_p1;

  logic        w_slot_end;
  logic        w_boundary;
  logic        w_strobe;
  logic        w_active;
  logic [7:0]  w_high_len;
  logic        w_dout_p0;

  // Wire order of the 24 bits; the shifter always emits bit 23 first.
  function automatic logic [23:0] order_word(input logic [23:0] rgb);
    if (GRB_ORDER != 0)
      return {rgb[15:8], rgb[23:16], rgb[7:0]};
    else
      return rgb;
  endfunction

  assign w_active   = (r_state == ST_DATA);
  assign w_slot_end = (r_cyc == C_LAST);
  assign w_boundary = w_slot_end && (r_bit_idx == 5'd0);
  // One slot ahead of the boundary, leaving T_BIT-2 cycles for the controller.
  assign w_strobe   = (r_cyc == 8'd0) && (r_bit_idx == 5'd0);
  assign w_high_len = r_shreg[23] ? C_T1H : C_T0H;
  assign w_dout_p0  = w_active && (r_cyc < w_high_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cyc     <= '0;
      r_bit_idx <= 5'd23;
      r_shreg   <= '0;
      r_tx_done <= 1'b0;
      r_dout_p1 <= 1'b0;
    end else begin
      r_tx_done <= w_strobe;

      if (w_slot_end) begin
        r_cyc     <= '0;
        r_bit_idx <= (r_bit_idx == 5'd0) ? 5'd23 : r_bit_idx - 5'd1;
      end else begin
        r_cyc     <= r_cyc + 8'd1;
      end

      // Inputs only matter here; everything else in the period is ignored.
      if (w_boundary) begin
        r_shreg <= bus.tx_en ? order_word(bus.rgb) : 24'd0;
        r_state <= bus.tx_en ? ST_DATA : ST_IDLE;
      end else if (w_slot_end) begin
        r_shreg <= {r_shreg[22:0], 1'b0};
      end

      // p0 -> p1: line register, lags the timebase by one clock
      r_dout_p1 <= w_dout_p0;
    end
  end

  assign bus.tx_done = r_tx_done;
  assign bus.busy    = w_active;
  assign o_dout      = r_dout_p1;

endmodule

// File: tb/tb_ws2812_bit_tx.sv
// Directed bench for ws2812_bit_tx: one GRB-order and one raw-order instance
// driven from a per-cycle stimulus table, with hand-computed pulse widths.
module tb_ws2812_bit_tx;

  logic clk;
  logic rst_n;
  logic w_dout_a;
  logic w_dout_b;
  int   tc;

  ws2812_bit_tx_if bus_a ();
  ws2812_bit_tx_if bus_b ();

  ws2812_bit_tx #(.T0H(20), .T1H(40), .T_BIT(63), .GRB_ORDER(1)) u_dut_grb (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus_a),
    .o_dout (w_dout_a)
  );

  ws2812_bit_tx #(.T0H(20), .T1H(40), .T_BIT(63), .GRB_ORDER(0)) u_dut_raw (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus_b),
    .o_dout (w_dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; outputs sampled 1 time unit after an edge belong to cycle tc.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tc <= 0;
    else        tc <= tc + 1;
  end

  int n_checks = 0;
  int n_errors = 0;
  int done_q[$];
  int busy_cnt;
  bit sched_on;
  int si;

  localparam int NS = 6;
  int          s_tc    [NS] = '{1451, 1522, 4476, 5988, 7500, 9012};
  bit          s_en    [NS] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [23:0] s_rgb_a [NS] = '{24'hFF0000, 24'h00FF00, 24'h0000FF,
                                24'hAAAAAA, 24'h000000, 24'hFFFFFF};
  logic [23:0] s_rgb_b [NS] = '{24'h800001, 24'h00FF00, 24'h0000FF,
                                24'hAAAAAA, 24'h000000, 24'hFFFFFF};

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int q_at(input int k);
    if (k < done_q.size()) return done_q[k];
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (sched_on && si < NS && tc == s_tc[si]) begin
      bus_a.tx_en = s_en[si];
      bus_b.tx_en = s_en[si];
      bus_a.rgb   = s_rgb_a[si];
      bus_b.rgb   = s_rgb_b[si];
      si++;
    end
    if (bus_a.tx_done) done_q.push_back(tc);
    if (bus_a.busy)    busy_cnt++;
  endtask

  task automatic goto_tc(input int n);
    while (tc < n) tick();
  endtask

  task automatic release_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    done_q.delete();
    busy_cnt = 0;
    rst_n = 1'b1;
  endtask

  // Captures 24 slots of 63 cycles, measuring the leading high run of each slot.
  task automatic capture_word(input string tag, input logic [23:0] exp_a,
                              input logic [23:0] exp_b);
    int run_a, run_b, stray_a, stray_b;
    bit lead_a, lead_b;
    stray_a = 0;
    stray_b = 0;
    for (int s = 0; s < 24; s++) begin
      run_a = 0; run_b = 0; lead_a = 1'b1; lead_b = 1'b1;
      for (int c = 0; c < 63; c++) begin
        if (w_dout_a) begin if (lead_a) run_a++; else stray_a++; end else lead_a = 1'b0;
        if (w_dout_b) begin if (lead_b) run_b++; else stray_b++; end else lead_b = 1'b0;
        tick();
      end
      check_val($sformatf("%s_grb_slot%0d", tag, s), run_a, exp_a[23-s] ? 40 : 20);
      check_val($sformatf("%s_raw_slot%0d", tag, s), run_b, exp_b[23-s] ? 40 : 20);
    end
    check_val({tag, "_grb_stray_high"}, stray_a, 0);
    check_val({tag, "_raw_stray_high"}, stray_b, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at tc=%0d", tc);
    $fatal(1, "watchdog");
  end

  initial begin
    int da, db;
    rst_n       = 1'b0;
    sched_on    = 1'b0;
    si          = 0;
    busy_cnt    = 0;
    bus_a.tx_en = 1'b0;
    bus_b.tx_en = 1'b0;
    bus_a.rgb   = 24'hFFFFFF;
    bus_b.rgb   = 24'hFFFFFF;
    #1;
    check_val("reset_dout",    w_dout_a,      0);
    check_val("reset_tx_done", bus_a.tx_done, 0);
    check_val("reset_busy",    bus_a.busy,    0);

    // Idle: tx_en held low for 10000 cycles.
    release_reset();
    da = 0; db = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (w_dout_a) da++;
      if (w_dout_b) db++;
    end
    check_val("idle_grb_dout_high", da, 0);
    check_val("idle_raw_dout_high", db, 0);
    check_val("idle_busy_cycles",   busy_cnt, 0);
    check_val("idle_done_count",    done_q.size(), 6);
    check_val("idle_done_0",        q_at(0), 1450);
    check_val("idle_done_1",        q_at(1), 2962);
    check_val("idle_done_2",        q_at(2), 4474);

    // Data words driven from the stimulus table.
    sched_on = 1'b1;
    si       = 0;
    release_reset();
    while (!bus_a.tx_done && tc < 3000) tick();
    check_val("first_done_tc", tc, 1450);
    goto_tc(1511);
    check_val("busy_before_word", bus_a.busy, 0);
    goto_tc(1512);
    check_val("busy_at_load", bus_a.busy, 1);
    goto_tc(1513);
    capture_word("w_ff0000", 24'h00FF00, 24'h800001);
    check_val("busy_word_cycles", busy_cnt, 1512);

    // Late rgb/tx_en change made the following word idle.
    da = 0; db = 0;
    for (int i = 0; i < 1512; i++) begin
      if (w_dout_a) da++;
      if (w_dout_b) db++;
      tick();
    end
    check_val("late_grb_idle_high", da, 0);
    check_val("late_raw_idle_high", db, 0);
    check_val("busy_after_idle", busy_cnt, 1514);

    capture_word("w_0000ff", 24'h0000FF, 24'h0000FF);
    capture_word("w_aaaaaa", 24'hAAAAAA, 24'hAAAAAA);
    capture_word("w_000000", 24'h000000, 24'h000000);
    check_val("stream_done_count", done_q.size(), 6);
    check_val("stream_done_1", q_at(1), 2962);
    check_val("stream_done_3", q_at(3), 5986);
    check_val("stream_done_4", q_at(4), 7498);
    check_val("stream_done_5", q_at(5), 9010);

    // Reset during bit 12 of the FFFFFF word.
    goto_tc(9840);
    check_val("pre_reset_grb_dout", w_dout_a, 1);
    check_val("pre_reset_raw_dout", w_dout_b, 1);
    rst_n = 1'b0;
    #1;
    check_val("async_reset_grb_dout", w_dout_a, 0);
    check_val("async_reset_raw_dout", w_dout_b, 0);
    check_val("async_reset_busy",     bus_a.busy, 0);
    release_reset();
    da = 0; db = 0;
    for (int i = 0; i < 1512; i++) begin
      tick();
      if (w_dout_a) da++;
      if (w_dout_b) db++;
    end
    check_val("post_reset_grb_idle_high", da, 0);
    check_val("post_reset_raw_idle_high", db, 0);
    check_val("post_reset_busy_cycles",   busy_cnt, 1);
    check_val("post_reset_done_count",    done_q.size(), 1);
    check_val("post_reset_done_0",        q_at(0), 1450);
    tick();
    check_val("post_reset_first_data_grb", w_dout_a, 1);
    check_val("post_reset_first_data_raw", w_dout_b, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ws2812_bit_tx.md
Name: ws2812_bit_tx

Overview:
- Bit-level serializer for the WS2812 LED chain. Sits directly downstream of the pixel-sequencing controller.
- Accepts one 24-bit colour word plus an enable per word period. Drives the single-wire NRZ data line (dout).
- Emits a one-cycle tx_done strobe once per word period so the controller can present the next word or time its reset gap.
- tx_done runs continuously, including while idle, so the controller's reset-gap counter keeps seeing strobes.

Parameters:
- T0H, 20: clk cycles dout stays high for a '0' bit (0.4 us at 50 MHz).
- T1H, 40: clk cycles dout stays high for a '1' bit (0.8 us).
- T_BIT, 63: clk cycles per bit slot (1.26 us). Legal range: 0 < T0H < T1H < T_BIT <= 255.
- GRB_ORDER, 1:
  - 1: send rgb[15:8], then rgb[23:16], then rgb[7:0], each byte MSB first.
  - 0: send rgb[23:0] MSB first.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- tx_en  in  1  word enable; sampled at the word boundary.
- rgb  in  24  colour word {R,G,B}; sampled at the word boundary.
- tx_done  out  1  one-cycle strobe at start of last bit slot of every word period.
- dout  out  1  registered WS2812 data line.
- busy  out  1  high while the current word period carries data (active).

Behaviour:
- Reset (async, rst_n=0): cyc=0, bit_idx=23, active=0, shreg=0, dout=0, tx_done=0, busy=0.
- Timebase, free-running after reset, never gated by tx_en:
  - cyc counts 0..T_BIT-1 and wraps.
  - On wrap, bit_idx decrements 23..0; 0 wraps to 23.
  - Word period = 24*T_BIT = 1512 cycles at defaults.
- tx_done: registered; high for exactly one cycle following the cycle where bit_idx==0 and cyc==0. First strobe after reset release lands at cycle 23*T_BIT+1 (1450); then every 1512 cycles, in all states.
- Word boundary is the cycle where bit_idx==0 and cyc==T_BIT-1. At that edge:
  - shreg <= ordered(rgb) if tx_en, else 0.
  - active <= tx_en.
  - busy follows active.
- Sampling margin: tx_done to boundary is T_BIT-2 cycles (>=2 required), so the controller may register tx_done and update rgb/tx_en up to 2 cycles later.
- rgb and tx_en changes at any other time have no effect on the word in flight.
- Current bit = shreg[23]. shreg shifts left by 1 at each bit-slot wrap, except at the word boundary, where it loads instead.
- dout next-state:
  - active && cyc < (shreg[23] ? T1H : T0H) -> 1.
  - otherwise -> 0.
  - Registered, so the line lags cyc by one clock; each pulse width is exactly T0H/T1H cycles and each slot is exactly T_BIT cycles.
- Idle word (active=0): dout held 0 for the whole period, so back-to-back idle words form the WS2812 reset/latch gap. The controller counts these cycles.
- Tx_en deasserted mid-word: ignored until the next boundary; the current word completes.
- tx_done and the boundary never coincide; there is no simultaneous-event case.
- Reset mid-word: dout drops to 0 asynchronously; the timebase restarts at bit_idx 23, cyc 0; the first word after reset is idle.
- Widths: cyc is 8 bits; bit_idx is 5 bits; the comparison is unsigned.

Test Plan:
- Idle check: release reset with tx_en=0 held. Required: dout stays 0 for 10000 cycles; tx_done strobes at cycles 1450, 2962 and 4474 (each 1 cycle wide); busy stays 0.
- GRB order: GRB_ORDER=1, drive rgb=24'hFF0000 and tx_en=1 one cycle after the first tx_done. Required:
  - next word has bits 0-7 at 20-cycle highs, bits 8-15 at 40-cycle highs, bits 16-23 at 20-cycle highs;
  - each slot is 63 cycles;
  - busy=1 for exactly 1512 cycles.
- Raw order: GRB_ORDER=0, rgb=24'h800001. Required: first and last bit 40-cycle highs, 22 middle bits 20-cycle highs.
- Late changes ignored: change rgb to 24'h00FF00 and drop tx_en 10 cycles after the boundary. Required: the in-flight word is sent unchanged; the following word is idle (dout low 1512 cycles); tx_done cadence is unchanged.
- Continuous stream: 3 consecutive words 24'h0000FF, 24'hAAAAAA, 24'h000000, each updated 2 cycles after tx_done. Required: 72 contiguous bit slots with correct widths and no gap slots.
- Reset mid-word: assert rst_n=0 during bit 12 of a data word while dout=1. Required:
  - dout=0 within the same cycle;
  - after release, the first tx_done is 1450 cycles later;
  - the first word is idle.
